// File: rtl/vga_pkg.sv
// Shared constants for the VGA line-fetch path: display geometry and the
// fixed 16-entry palette used to expand 4-bit source pixels to 24-bit RGB.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_TOTAL  = 525;
    localparam int unsigned SRC_W    = 320;
    localparam int unsigned SRC_H    = 240;

    // CGA-style palette, {R,G,B}; index 0 is black, index 15 is white.
    localparam logic [23:0] PALETTE [0:15] = '{
        24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
        24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
        24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
        24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
    };

    function automatic logic [23:0] palette_lookup(input logic [3:0] idx);
        return PALETTE[idx];
    endfunction

endpackage

// File: rtl/line_buffer_2bank.sv
// Two-bank line buffer: one write port, one synchronous read port.
// A read and write to the same location in one cycle returns the old word.
module line_buffer_2bank #(
    parameter int unsigned DEPTH = 80,
    parameter int unsigned AW    = 7
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic          wbank_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [15:0]   wdata_i,
    input  logic          rbank_i,
    input  logic [AW-1:0] raddr_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem_q [2][DEPTH];
    logic [15:0] rd_q;

    // Write port; out-of-range addresses are dropped.
    always_ff @(posedge clk_i) begin
        if (we_i && (32'(waddr_i) < DEPTH)) begin
            mem_q[wbank_i][waddr_i] <= wdata_i;
        end
    end

    // Registered read; out-of-range addresses hold the previous word.
    always_ff @(posedge clk_i) begin
        if (32'(raddr_i) < DEPTH) begin
            rd_q <= mem_q[rbank_i][raddr_i];
        end
    end

    assign rdata_o = rd_q;

endmodule

// File: rtl/vga_line_fetch.sv
// VGA line fetcher: prefetches the next 320-pixel 4bpp source row into a
// two-bank line buffer on each line change and renders the current row with
// 2x2 pixel doubling through a fixed palette.
module vga_line_fetch
    import vga_pkg::*;
#(
    parameter logic [14:0] FB_BASE   = 15'h0000,
    parameter int unsigned ROW_WORDS = 80
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        VGA_BLANK_N,
    output logic [14:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        underflow
);

    localparam int unsigned WW = $clog2(ROW_WORDS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [WW-1:0] word_q,  word_d;
    logic          bank_q,  bank_d;
    logic [14:0]   addr_q,  addr_d;
    logic          rd_q,    rd_d;
    logic          uf_q,    uf_d;
    logic [9:0]    prev_y_q;

    logic          line_evt;
    logic          last_line;
    logic          fetch_go;
    logic [7:0]    fetch_row;
    logic [14:0]   row_base;
    logic          wr_en;

    logic          vis_q;
    logic [1:0]    pix_k_q;
    logic [15:0]   line_word;
    logic [3:0]    pix_idx;
    logic [23:0]   rgb;

    assign line_evt  = (DrawY != prev_y_q);
    assign last_line = (DrawY == 10'(V_TOTAL - 1));
    assign fetch_go  = line_evt && (last_line || (!DrawY[0] && (DrawY < 10'(V_ACTIVE - 2))));
    assign fetch_row = last_line ? 8'd0 : (8'(DrawY[9:1]) + 8'd1);
    assign row_base  = FB_BASE + (15'(fetch_row) * 15'(ROW_WORDS));

    // Previous-line register for line-change detection.
    always_ff @(posedge Clk) begin
        if (Reset) prev_y_q <= '0;
        else       prev_y_q <= DrawY;
    end

    // Fetch FSM next-state; a new fetch start overrides any fetch in flight.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        uf_d    = uf_q;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: ;
            S_REQ:  state_d = S_WAIT;
            S_WAIT: begin
                if (mem_ack) begin
                    wr_en = 1'b1;
                    if (word_q == WW'(ROW_WORDS - 1)) begin
                        state_d = S_IDLE;
                        rd_d    = 1'b0;
                    end else begin
                        state_d = S_REQ;
                        word_d  = word_q + 1'b1;
                        addr_d  = addr_q + 15'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                rd_d    = 1'b0;
            end
        endcase
        if (fetch_go) begin
            if (state_q != S_IDLE) uf_d = 1'b1;
            state_d = S_REQ;
            word_d  = '0;
            bank_d  = fetch_row[0];
            addr_d  = row_base;
            rd_d    = 1'b1;
            wr_en   = 1'b0;
        end
    end

    // Fetch FSM state and registered memory-request outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            bank_q  <= 1'b0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            uf_q    <= uf_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_rd    = rd_q;
    assign underflow = uf_q;

    line_buffer_2bank #(
        .DEPTH (ROW_WORDS),
        .AW    (WW)
    ) u_lbuf (
        .clk_i   (Clk),
        .we_i    (wr_en),
        .wbank_i (bank_q),
        .waddr_i (word_q),
        .wdata_i (mem_rdata),
        .rbank_i (DrawY[1]),
        .raddr_i (WW'(DrawX >> 3)),
        .rdata_o (line_word)
    );

    // Visibility and nibble select, aligned with the buffer's read register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vis_q   <= 1'b0;
            pix_k_q <= '0;
        end else begin
            vis_q   <= VGA_BLANK_N && (DrawX < 10'(H_ACTIVE)) && (DrawY < 10'(V_ACTIVE));
            pix_k_q <= DrawX[2:1];
        end
    end

    // Palette decode sits after the read register so colour lags inputs by one cycle.
    always_comb begin
        pix_idx = line_word[{pix_k_q, 2'b00} +: 4];
        rgb     = vis_q ? palette_lookup(pix_idx) : '0;
    end

    assign VGA_R = rgb[23:16];
    assign VGA_G = rgb[15:8];
    assign VGA_B = rgb[7:0];

endmodule

// File: tb/tb_vga_line_fetch.sv
// Randomized self-checking bench for vga_line_fetch with a framebuffer
// memory model and a pixel-level reference derived from source coordinates.
`timescale 1ns/1ps
module tb_vga_line_fetch;

    localparam int RW = 80;
    localparam int FB_WORDS = 19200;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX, DrawY;
    logic        VGA_BLANK_N;
    logic [14:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        underflow;

    logic [15:0] fb [0:FB_WORDS-1];
    logic [23:0] pal [0:15] = '{
        24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
        24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
        24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
        24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
    };
    int exp039 [0:7] = '{5, 5, 10, 10, 0, 0, 15, 15};

    int checks = 0;
    int errors = 0;
    bit ack_en;
    int cnt;
    int ack_q[$];

    always #5 Clk = ~Clk;

    vga_line_fetch #(
        .FB_BASE   (15'h0000),
        .ROW_WORDS (RW)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .VGA_BLANK_N (VGA_BLANK_N),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .VGA_R       (VGA_R),
        .VGA_G       (VGA_G),
        .VGA_B       (VGA_B),
        .underflow   (underflow)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: acknowledges in the third cycle of each request.
    always @(negedge Clk) begin
        if (!ack_en) begin
            cnt = 0;
        end else if (mem_ack) begin
            mem_ack   = 1'b0;
            mem_rdata = 16'($urandom);
            cnt       = mem_rd ? 1 : 0;
        end else if (mem_rd) begin
            cnt++;
            if (cnt == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = (int'(mem_addr) < FB_WORDS) ? fb[mem_addr] : 16'hDEAD;
                ack_q.push_back(int'(mem_addr));
            end
        end else begin
            cnt = 0;
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_idle();
        repeat (2) step();
        for (int i = 0; i < 2000 && mem_rd; i++) step();
        check_eq("fetch_done", 32'(mem_rd), 0);
    endtask

    function automatic logic [23:0] exp_rgb(input int x, input int y, input bit bn);
        logic [15:0] w;
        int k;
        if (!bn || x >= 640 || y >= 480) return 24'h0;
        w = fb[(y / 2) * RW + (x / 8)];
        k = (x / 2) % 4;
        return pal[w[4*k +: 4]];
    endfunction

    task automatic sweep(input int y, input int n);
        int x;
        bit bn;
        DrawY = 10'(y);
        for (int i = 0; i < n; i++) begin
            x = $urandom_range(0, 799);
            bn = ($urandom_range(0, 7) != 0);
            DrawX = 10'(x);
            VGA_BLANK_N = bn;
            step();
            check_eq("pixel", {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, exp_rgb(x, y, bn)});
        end
        VGA_BLANK_N = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r, y0;
        for (int i = 0; i < FB_WORDS; i++) fb[i] = 16'($urandom);
        fb[0] = 16'hF0A5;
        ack_en = 1'b1;
        mem_ack = 1'b0;
        mem_rdata = '0;
        Reset = 1'b1;
        DrawX = '0;
        DrawY = '0;
        VGA_BLANK_N = 1'b1;
        repeat (3) step();
        check_eq("rst_mem_rd", 32'(mem_rd), 0);
        check_eq("rst_mem_addr", 32'(mem_addr), 0);
        check_eq("rst_underflow", 32'(underflow), 0);
        check_eq("rst_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 0);
        Reset = 1'b0;
        step();

        // Frame-end prefetch of row 0
        DrawY = 10'd523;
        repeat (2) step();
        check_eq("no_fetch_523", 32'(mem_rd), 0);
        ack_q.delete();
        DrawY = 10'd524;
        for (int i = 0; i < 1000 && ack_q.size() < 80; i++) step();
        check_eq("rd_after_last_ack", 32'(mem_rd), 0);
        check_eq("row0_ack_count", 32'(ack_q.size()), 80);
        foreach (ack_q[i]) check_eq("row0_addr", 32'(ack_q[i]), 32'(i));
        check_eq("row0_underflow", 32'(underflow), 0);

        // Nibble ordering within word 0 of bank 0
        DrawY = 10'd0;
        for (int x = 0; x < 8; x++) begin
            DrawX = 10'(x);
            step();
            check_eq("pix_nibble", {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, pal[exp039[x]]});
        end
        wait_idle();

        // Line 10 fetches row 6 into bank 0
        DrawY = 10'd9;
        step();
        ack_q.delete();
        DrawY = 10'd10;
        wait_idle();
        check_eq("row6_count", 32'(ack_q.size()), 80);
        check_eq("row6_first", 32'(ack_q[0]), 480);
        check_eq("row6_last", 32'(ack_q[ack_q.size() - 1]), 559);
        sweep(12, 150);
        wait_idle();

        // Random rows
        repeat (4) begin
            r = $urandom_range(1, 239);
            y0 = 2 * r - 2;
            if (int'(DrawY) == y0) begin
                DrawY = 10'(y0 + 1);
                repeat (2) step();
            end
            DrawY = 10'(y0);
            wait_idle();
            sweep(2 * r + $urandom_range(0, 1), 120);
            wait_idle();
        end

        // Underflow: fetch restarted before completion
        DrawY = 10'd9;
        repeat (2) step();
        ack_en = 1'b0;
        DrawY = 10'd10;
        repeat (2) step();
        check_eq("uf_first_addr", 32'(mem_addr), 480);
        check_eq("uf_rd_high", 32'(mem_rd), 1);
        DrawY = 10'd11;
        repeat (2) step();
        check_eq("uf_not_yet", 32'(underflow), 0);
        check_eq("uf_addr_stable", 32'(mem_addr), 480);
        DrawY = 10'd12;
        step();
        check_eq("uf_set", 32'(underflow), 1);
        check_eq("uf_restart_addr", 32'(mem_addr), 560);
        check_eq("uf_restart_rd", 32'(mem_rd), 1);
        ack_en = 1'b1;
        wait_idle();
        sweep(14, 150);
        wait_idle();

        // Reset during WAIT_ACK at word 40
        DrawY = 10'd20;
        for (int i = 0; i < 400 && !(mem_rd && mem_addr == 15'd920); i++) step();
        check_eq("reach_word40", 32'(mem_addr), 920);
        step();
        ack_en = 1'b0;
        check_eq("uf_before_reset", 32'(underflow), 1);
        Reset = 1'b1;
        DrawY = 10'd1;
        step();
        check_eq("midrst_rd", 32'(mem_rd), 0);
        check_eq("midrst_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 0);
        check_eq("midrst_uf", 32'(underflow), 0);
        check_eq("midrst_addr", 32'(mem_addr), 0);
        Reset = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 16'hFFFF;
        step();
        mem_ack = 1'b0;
        check_eq("late_ack_rd", 32'(mem_rd), 0);
        step();
        check_eq("late_ack_rd2", 32'(mem_rd), 0);
        check_eq("late_ack_uf", 32'(underflow), 0);
        ack_en = 1'b1;

        // Blanking forces black
        DrawX = 10'd100;
        DrawY = 10'd100;
        VGA_BLANK_N = 1'b0;
        step();
        check_eq("blank_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 0);
        VGA_BLANK_N = 1'b1;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_line_fetch.md
VGA_LINE_FETCH -- requirements
Module: vga_line_fetch

Interface
REQ-001 Parameter FB_BASE, default 15'h0000, framebuffer base word address.
REQ-002 Parameter ROW_WORDS, default 80, 16-bit words per 320-pixel source row.
REQ-003 Clk  input  1  system clock; one clock domain; all logic on posedge Clk.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 DrawX  input  10  current horizontal pixel coordinate from the VGA timing stage.
REQ-006 DrawY  input  10  current vertical line coordinate, 0..524.
REQ-007 VGA_BLANK_N  input  1  active-low blanking from the VGA timing stage.
REQ-008 mem_addr  output  15  framebuffer word address.
REQ-009 mem_rd  output  1  read request, held until acknowledged.
REQ-010 mem_ack  input  1  one-cycle acknowledge; mem_rdata valid in the same cycle.
REQ-011 mem_rdata  input  16  four 4-bit palette indices; pixel k in bits [4k+3:4k].
REQ-012 VGA_R, VGA_G, VGA_B  output  8 each  pixel colour.
REQ-013 underflow  output  1  sticky: a row fetch was incomplete when needed.

Function
REQ-014 Source image is 320x240, 4 bpp; each source pixel covers 2x2 display pixels.
REQ-015 Line buffer: two banks of ROW_WORDS x 16 bits; source row r lives in bank r[0].
REQ-016 Line-change detect: register DrawY as prev_y; a line event fires the cycle DrawY != prev_y.
REQ-017 On a line event with DrawY == 524: start fetch of source row 0 into bank 0.
REQ-018 On a line event with DrawY even and DrawY < 478: start fetch of row DrawY/2+1 into bank (DrawY/2+1)[0].
REQ-019 Other line events start no fetch.
REQ-020 FSM states IDLE, REQ, WAIT_ACK; IDLE->REQ on fetch start; REQ drives mem_rd=1, mem_addr=FB_BASE+row*ROW_WORDS+word, moves to WAIT_ACK.
REQ-021 WAIT_ACK holds mem_rd and mem_addr stable; on mem_ack writes mem_rdata to bank[word]; word==ROW_WORDS-1 -> IDLE, else word+1 -> REQ.
REQ-022 At most one request outstanding; mem_rd deasserts the cycle after the final ack.
REQ-023 Fetch start while not IDLE: set underflow, abandon current fetch, restart at word 0 of the new row the next cycle.
REQ-024 Address arithmetic is 15-bit unsigned; row*ROW_WORDS never exceeds 19199.
REQ-025 Display read: word = DrawX>>3, k = (DrawX>>1)&3, bank = (DrawY>>1)[0]; palette index = nibble k.
REQ-026 RGB registered: outputs reflect DrawX/DrawY/VGA_BLANK_N sampled exactly 1 Clk earlier.
REQ-027 VGA_BLANK_N==0 or DrawX>=640 or DrawY>=480 -> RGB = 0.
REQ-028 Palette: fixed 16-entry 24-bit table; index 0 = 000000, index 15 = FFFFFF.
REQ-029 Read and fetch-write to the same bank in the same cycle: write wins at memory, read returns old word (no bypass).
REQ-030 First frame after reset has no row-0 prefetch; its contents are undefined and do not set underflow.

Reset
REQ-031 Reset: FSM IDLE, mem_rd=0, mem_addr=0, word=0, prev_y=0, underflow=0, VGA_R/G/B=0.
REQ-032 Reset mid-fetch drops mem_rd the next cycle; a late mem_ack in IDLE is ignored.
REQ-033 Line buffer contents are not reset.

Structure
REQ-034 Package vga_pkg holds palette table, H_ACTIVE=640, V_ACTIVE=480, V_TOTAL=525, SRC_W=320, SRC_H=240.
REQ-035 Sub-module line_buffer_2bank (1 write port, 1 read port, synchronous read) holds both banks.
REQ-036 Fetch FSM and pixel mapping reside in vga_line_fetch.

Verification
REQ-037 DrawY 523->524, ack every 3rd cycle -> 80 requests, mem_addr 0..79, mem_rd low after 80th ack, underflow 0.
REQ-038 DrawY 9->10 -> fetch row 6, first mem_addr FB_BASE+480, last +559, writes bank 0.
REQ-039 Bank 0 word 0 = 16'hF0A5, DrawY=0, DrawX=0..7 -> indices 5,5,A,A,0,0,F,F one cycle later.
REQ-040 mem_ack held low, DrawY 10->11->12 -> underflow=1, fetch restarts at row 7 address FB_BASE+560.
REQ-041 Reset asserted in WAIT_ACK at word 40 -> next cycle mem_rd=0, RGB=0, underflow=0.
REQ-042 VGA_BLANK_N=0 with DrawX=100, DrawY=100 -> RGB = 0,0,0.
